pipe_stage_elastic: RTL

- Parametrised elastic pipeline stage for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the plain enable/flush register with a valid/ready handshake and an optional 2-entry skid buffer.
- A downstream stall no longer needs a combinational enable path back to upstream.
- Supports flush with a programmable bubble value and reports its occupancy.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_data_reg.sv | 22 ++
 rtl/pipe_stage_elastic.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: state encoding and bubble constant.
package pipe_pkg;

  // Stage occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Payload loaded into a flushed stage so downstream sees a harmless bubble.
  localparam logic [31:0] PIPE_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/pipe_data_reg.sv
// Falling-edge payload register with load enable and asynchronous active-low reset.
module pipe_data_reg #(
  parameter int                N_BITS      = 32,
  parameter logic [N_BITS-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [N_BITS-1:0] d,
  output logic [N_BITS-1:0] q
);

  // Capture d on a falling edge when load is set; reset forces RESET_VALUE.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer and flush.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                N_BITS       = 32,
  parameter logic [N_BITS-1:0] RESET_VALUE  = '0,
  parameter logic [N_BITS-1:0] FLUSH_VALUE  = N_BITS'(PIPE_BUBBLE),
  parameter bit                FLUSH_ENABLE = 1'b1,
  parameter bit                SKID_ENABLE  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_BITS-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_BITS-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  pipe_state_t       state;
  pipe_state_t       next_state;
  logic              ready_reg;
  logic              flush;
  logic              accept;
  logic              drain;
  logic              head_load;
  logic              skid_load;
  logic [N_BITS-1:0] head_d;
  logic [N_BITS-1:0] skid_d;
  logic [N_BITS-1:0] skid_q;

  assign flush       = FLUSH_ENABLE & flush_i;
  assign out_valid_o = (state != PS_EMPTY);
  assign occupancy_o = state;

  // In skid mode ready is purely registered; single-entry mode lets a drain free the slot in the same cycle.
  assign in_ready_o  = SKID_ENABLE ? ready_reg
                                   : (ready_reg & (~out_valid_o | out_ready_i));
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = out_valid_o & out_ready_i;

  // Next-state and entry-load decisions; flush overrides any accept or drain.
  always_comb begin
    next_state = state;
    head_load  = 1'b0;
    head_d     = in_data_i;
    skid_load  = 1'b0;
    skid_d     = in_data_i;
    if (flush) begin
      next_state = PS_EMPTY;
      head_load  = 1'b1;
      head_d     = FLUSH_VALUE;
      skid_load  = 1'b1;
      skid_d     = '0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (accept) begin
            next_state = PS_HALF;
            head_load  = 1'b1;
          end
        end
        PS_HALF: begin
          if (accept && drain) begin
            head_load = 1'b1;
          end else if (accept && SKID_ENABLE) begin
            next_state = PS_FULL;
            skid_load  = 1'b1;
          end else if (drain) begin
            next_state = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (drain) begin
            next_state = PS_HALF;
            head_load  = 1'b1;
            head_d     = skid_q;
          end
        end
        default: next_state = PS_EMPTY;
      endcase
    end
  end

  // State and registered ready; ready stays low until the first edge after reset release.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PS_EMPTY;
      ready_reg <= 1'b0;
    end else begin
      state     <= next_state;
      ready_reg <= SKID_ENABLE ? (next_state != PS_FULL) : 1'b1;
    end
  end

  pipe_data_reg #(
    .N_BITS      (N_BITS),
    .RESET_VALUE (RESET_VALUE)
  ) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .d     (head_d),
    .q     (out_data_o)
  );

  generate
    if (SKID_ENABLE) begin : g_skid
      pipe_data_reg #(
        .N_BITS      (N_BITS),
        .RESET_VALUE ('0)
      ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (skid_d),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      logic skid_unused;
      assign skid_q      = '0;
      assign skid_unused = skid_load ^ (^skid_d);
    end
  endgenerate

endmodule
